// File: rtl/keyboard_ctl_pkg.sv
// Shared key codes, key indices and FSM state for the keyboard controller.
package keyboard_ctl_pkg;

  localparam int unsigned WORD_W    = 16;
  localparam int unsigned N_KEYS    = 6;
  localparam int unsigned KEY_IDX_W = 3;

  typedef enum logic [KEY_IDX_W-1:0] {
    KEY_W     = 3'd0,
    KEY_A     = 3'd1,
    KEY_S     = 3'd2,
    KEY_D     = 3'd3,
    KEY_SPACE = 3'd4,
    KEY_ENTER = 3'd5
  } key_e;

  typedef enum logic {
    ST_MAKE  = 1'b0,
    ST_BREAK = 1'b1
  } state_e;

  typedef struct packed {
    logic known;
    key_e idx;
  } key_dec_t;

  // Scan codes carried as two ASCII hex characters
  localparam logic [WORD_W-1:0] CODE_W        = 16'h3144;
  localparam logic [WORD_W-1:0] CODE_A        = 16'h3143;
  localparam logic [WORD_W-1:0] CODE_S        = 16'h3142;
  localparam logic [WORD_W-1:0] CODE_D        = 16'h3233;
  localparam logic [WORD_W-1:0] CODE_SPACE    = 16'h3239;
  localparam logic [WORD_W-1:0] CODE_ENTER    = 16'h3541;
  localparam logic [WORD_W-1:0] CODE_RELEASED = 16'h4630;

endpackage

// File: rtl/keyboard_key_decode.sv
// Maps an ASCII-hex key word to a tracked-key index; known=0 for anything else.
module keyboard_key_decode
  import keyboard_ctl_pkg::*;
(
  input  logic [WORD_W-1:0] key_word,
  output key_dec_t          dec_c
);

  always_comb begin
    dec_c.known = 1'b1;
    dec_c.idx   = KEY_W;
    case (key_word)
      CODE_W:     dec_c.idx = KEY_W;
      CODE_A:     dec_c.idx = KEY_A;
      CODE_S:     dec_c.idx = KEY_S;
      CODE_D:     dec_c.idx = KEY_D;
      CODE_SPACE: dec_c.idx = KEY_SPACE;
      CODE_ENTER: dec_c.idx = KEY_ENTER;
      default:    dec_c.known = 1'b0;
    endcase
  end

endmodule

// File: rtl/keyboard_ctl.sv
// Make/break tracker producing a held-key mask, press/release pulses,
// a SPACE action handshake and a stuck-key auto-release.
module keyboard_ctl
  import keyboard_ctl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] key_word,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic              freeze,
  output logic [N_KEYS-1:0] held,
  output logic [N_KEYS-1:0] press,
  // "release" is a reserved word, hence the suffix
  output logic [N_KEYS-1:0] release_pulse,
  output logic              action_req,
  input  logic              action_ack
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  state_e            state, state_n;
  logic [N_KEYS-1:0] held_n, press_n, rel_n;
  logic              act_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              accept;
  key_dec_t          dec;

  keyboard_key_decode u_decode (
    .key_word (key_word),
    .dec_c    (dec)
  );

  assign key_ready = !freeze;
  assign accept    = key_valid && !freeze;

  // Next-state: word handling has priority over the stuck-key timeout
  always_comb begin
    state_n = state;
    held_n  = held;
    press_n = '0;
    rel_n   = '0;
    act_n   = action_req;
    cnt_n   = cnt;
    if (accept) begin
      cnt_n = '0;
      case (state)
        ST_MAKE: begin
          if (key_word == CODE_RELEASED) begin
            state_n = ST_BREAK;
          end else if (dec.known && !held[dec.idx]) begin
            held_n[dec.idx]  = 1'b1;
            press_n[dec.idx] = 1'b1;
          end
        end
        ST_BREAK: begin
          if (key_word != CODE_RELEASED) begin
            state_n = ST_MAKE;
            if (dec.known && held[dec.idx]) begin
              held_n[dec.idx] = 1'b0;
              rel_n[dec.idx]  = 1'b1;
            end
          end
        end
      endcase
    end else if (held != '0) begin
      if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        held_n  = '0;
        rel_n   = held;
        cnt_n   = '0;
        state_n = ST_MAKE;
      end else begin
        cnt_n = cnt + CNT_W'(1);
      end
    end
    if (press_n[KEY_SPACE]) act_n = 1'b1;
    if (action_ack)         act_n = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_MAKE;
      held          <= '0;
      press         <= '0;
      release_pulse <= '0;
      action_req    <= 1'b0;
      cnt           <= '0;
    end else begin
      state         <= state_n;
      held          <= held_n;
      press         <= press_n;
      release_pulse <= rel_n;
      action_req    <= act_n;
      cnt           <= cnt_n;
    end
  end

endmodule

// File: tb/tb_keyboard_ctl.sv
// Directed bench for keyboard_ctl: per-cycle vector table plus timeout and reset sequences.
module tb_keyboard_ctl;

  localparam logic [15:0] KW  = 16'h3144;
  localparam logic [15:0] KA  = 16'h3143;
  localparam logic [15:0] KS  = 16'h3142;
  localparam logic [15:0] KD  = 16'h3233;
  localparam logic [15:0] KSP = 16'h3239;
  localparam logic [15:0] KEN = 16'h3541;
  localparam logic [15:0] KF0 = 16'h4630;
  localparam logic [15:0] KUN = 16'h1234;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] key_word;
  logic        key_valid;
  logic        key_ready;
  logic        freeze;
  logic [5:0]  held;
  logic [5:0]  press;
  logic [5:0]  release_pulse;
  logic        action_req;
  logic        action_ack;

  int total = 0;
  int bad   = 0;

  keyboard_ctl #(.TIMEOUT_CYCLES(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_word      (key_word),
    .key_valid     (key_valid),
    .key_ready     (key_ready),
    .freeze        (freeze),
    .held          (held),
    .press         (press),
    .release_pulse (release_pulse),
    .action_req    (action_req),
    .action_ack    (action_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    logic        valid;
    logic        frz;
    logic        ack;
    logic [5:0]  e_held;
    logic [5:0]  e_press;
    logic [5:0]  e_rel;
    logic        e_act;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [15:0] w, input logic vl, input logic fz, input logic ak,
                     input logic [5:0] h, input logic [5:0] p, input logic [5:0] r,
                     input logic a);
    vec_t v;
    v.word = w; v.valid = vl; v.frz = fz; v.ack = ak;
    v.e_held = h; v.e_press = p; v.e_rel = r; v.e_act = a;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string nm, input logic [5:0] h, input logic [5:0] p,
                          input logic [5:0] r, input logic a);
    chk({nm, " held"},   16'(held), 16'(h));
    chk({nm, " press"},  16'(press), 16'(p));
    chk({nm, " rel"},    16'(release_pulse), 16'(r));
    chk({nm, " act"},    16'(action_req), 16'(a));
  endtask

  // Drive one cycle's inputs, then sample just after the next rising edge
  task automatic cyc(input logic [15:0] w, input logic vl, input logic fz, input logic ak);
    key_word = w; key_valid = vl; freeze = fz; action_ack = ak;
    @(posedge clk);
    #1;
    key_valid = 1'b0; freeze = 1'b0; action_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; key_word = '0; key_valid = 1'b0; freeze = 1'b0; action_ack = 1'b0;
    #12;
    chk_outs("reset", 6'b0, 6'b0, 6'b0, 1'b0);
    chk("reset ready", 16'(key_ready), 16'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // W make/break
    add(KW,  1, 0, 0, 6'b000001, 6'b000001, 6'b000000, 0);
    add(KF0, 1, 0, 0, 6'b000001, 6'b000000, 6'b000000, 0);
    add(KW,  1, 0, 0, 6'b000000, 6'b000000, 6'b000001, 0);
    add(KW,  0, 0, 0, 6'b000000, 6'b000000, 6'b000000, 0);
    // typematic W then D
    add(KW,  1, 0, 0, 6'b000001, 6'b000001, 6'b000000, 0);
    for (int i = 0; i < 5; i++)
      add(KW, 1, 0, 0, 6'b000001, 6'b000000, 6'b000000, 0);
    add(KD,  1, 0, 0, 6'b001001, 6'b001000, 6'b000000, 0);
    add(KF0, 1, 0, 0, 6'b001001, 6'b000000, 6'b000000, 0);
    add(KW,  1, 0, 0, 6'b001000, 6'b000000, 6'b000001, 0);
    add(KF0, 1, 0, 0, 6'b001000, 6'b000000, 6'b000000, 0);
    add(KD,  1, 0, 0, 6'b000000, 6'b000000, 6'b001000, 0);
    // SPACE twice without ack, then ack
    add(KSP, 1, 0, 0, 6'b010000, 6'b010000, 6'b000000, 1);
    add(KF0, 1, 0, 0, 6'b010000, 6'b000000, 6'b000000, 1);
    add(KSP, 1, 0, 0, 6'b000000, 6'b000000, 6'b010000, 1);
    add(KSP, 1, 0, 0, 6'b010000, 6'b010000, 6'b000000, 1);
    add(KSP, 0, 0, 1, 6'b010000, 6'b000000, 6'b000000, 0);
    add(KSP, 0, 0, 0, 6'b010000, 6'b000000, 6'b000000, 0);
    add(KF0, 1, 0, 0, 6'b010000, 6'b000000, 6'b000000, 0);
    add(KSP, 1, 0, 0, 6'b000000, 6'b000000, 6'b010000, 0);
    // break, unknown, then S is a make; frozen break word is not taken
    add(KF0, 1, 0, 0, 6'b000000, 6'b000000, 6'b000000, 0);
    add(KUN, 1, 0, 0, 6'b000000, 6'b000000, 6'b000000, 0);
    add(KS,  1, 0, 0, 6'b000100, 6'b000100, 6'b000000, 0);
    add(KF0, 1, 1, 0, 6'b000100, 6'b000000, 6'b000000, 0);
    add(KS,  1, 0, 0, 6'b000100, 6'b000000, 6'b000000, 0);
    add(KF0, 1, 0, 0, 6'b000100, 6'b000000, 6'b000000, 0);
    add(KS,  1, 0, 0, 6'b000000, 6'b000000, 6'b000100, 0);
    // SPACE press with ack in the same cycle: ack wins
    add(KSP, 1, 0, 1, 6'b010000, 6'b010000, 6'b000000, 0);
    add(KSP, 0, 0, 0, 6'b010000, 6'b000000, 6'b000000, 0);
    add(KF0, 1, 0, 0, 6'b010000, 6'b000000, 6'b000000, 0);
    add(KF0, 1, 0, 0, 6'b010000, 6'b000000, 6'b000000, 0);
    add(KSP, 1, 0, 0, 6'b000000, 6'b000000, 6'b010000, 0);
    // ENTER
    add(KEN, 1, 0, 0, 6'b100000, 6'b100000, 6'b000000, 0);
    add(KF0, 1, 0, 0, 6'b100000, 6'b000000, 6'b000000, 0);
    add(KEN, 1, 0, 0, 6'b000000, 6'b000000, 6'b100000, 0);

    foreach (vecs[i]) begin
      key_word = vecs[i].word; key_valid = vecs[i].valid;
      freeze = vecs[i].frz; action_ack = vecs[i].ack;
      #1;
      chk($sformatf("vec%0d ready", i), 16'(key_ready), 16'(!vecs[i].frz));
      @(posedge clk);
      #1;
      chk_outs($sformatf("vec%0d", i), vecs[i].e_held, vecs[i].e_press,
               vecs[i].e_rel, vecs[i].e_act);
    end
    key_valid = 1'b0; freeze = 1'b0; action_ack = 1'b0;

    // Timeout: A held with no traffic releases on the 16th cycle after accept
    cyc(KA, 1, 0, 0);
    chk_outs("to accept", 6'b000010, 6'b000010, 6'b0, 1'b0);
    for (int i = 1; i <= 17; i++) begin
      cyc(KA, 0, 0, 0);
      if (i < 16)       chk_outs($sformatf("to c%0d", i), 6'b000010, 6'b0, 6'b0, 1'b0);
      else if (i == 16) chk_outs("to fire", 6'b0, 6'b0, 6'b000010, 1'b0);
      else              chk_outs("to after", 6'b0, 6'b0, 6'b0, 1'b0);
    end

    // Word accepted on the would-be timeout edge suppresses it and restarts the count
    cyc(KA, 1, 0, 0);
    for (int i = 1; i <= 15; i++) cyc(KA, 0, 0, 0);
    cyc(KA, 1, 0, 0);
    chk_outs("sup edge", 6'b000010, 6'b0, 6'b0, 1'b0);
    for (int i = 1; i <= 15; i++) cyc(KA, 0, 0, 0);
    chk_outs("sup c15", 6'b000010, 6'b0, 6'b0, 1'b0);
    cyc(KA, 0, 0, 0);
    chk_outs("sup fire", 6'b0, 6'b0, 6'b000010, 1'b0);

    // Timeout while a break prefix is pending returns the FSM to make
    cyc(KS, 1, 0, 0);
    cyc(KF0, 1, 0, 0);
    for (int i = 1; i <= 16; i++) cyc(KS, 0, 0, 0);
    chk_outs("to brk fire", 6'b0, 6'b0, 6'b000100, 1'b0);
    cyc(KS, 1, 0, 0);
    chk_outs("to brk make", 6'b000100, 6'b000100, 6'b0, 1'b0);
    cyc(KF0, 1, 0, 0);
    cyc(KS, 1, 0, 0);

    // Reset while a break is pending
    cyc(KSP, 1, 0, 0);
    cyc(KS, 1, 0, 0);
    chk_outs("pre rst", 6'b010100, 6'b000100, 6'b0, 1'b1);
    cyc(KF0, 1, 0, 0);
    rst_n = 1'b0;
    #1;
    chk_outs("mid rst", 6'b0, 6'b0, 6'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cyc(KS, 1, 0, 0);
    chk_outs("post rst", 6'b000100, 6'b000100, 6'b0, 1'b0);
    cyc(KS, 0, 0, 0);
    chk_outs("post rst idle", 6'b000100, 6'b0, 6'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keyboard_ctl.md
# keyboard_ctl

Keyboard controller between the keyboard code receiver and the game logic. Consumes the stream of 16-bit key words (two ASCII hex characters per scan code), tracks make/break sequences with a two-state FSM, and maintains a held-key bitmask for W, A, S, D, SPACE and ENTER. Emits one-cycle press/release pulses, a SPACE action request with acknowledge handshake, and auto-releases all keys after a stuck-key timeout.

## Interface
- TIMEOUT_CYCLES, default 65_000_000: cycles with no accepted word before held keys are force-released; minimum 2.
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous and active-low
- key_word  in  16  key code, ASCII-hex encoded (package constants W, A, S, D, SPACE, ENTER, RELEASED)
- key_valid  in  1  key_word valid
- key_ready  out  1  word accepted when key_valid && key_ready
- freeze  in  1  stall input; key_ready = !freeze
- held  out  6  held-key mask, index per package key enum
- press  out  6  one-cycle pulse per key on make (first make only)
- release  out  6  one-cycle pulse per key on break or timeout
- action_req  out  1  SPACE action pending
- action_ack  in  1  clears action_req

## Operation
- FSM states: ST_MAKE (reset), ST_BREAK.
- ST_MAKE, word == RELEASED -> ST_BREAK, no output change.
- ST_MAKE, known key k: if held[k]==0, set held[k], pulse press[k]; if already held (typematic repeat), no pulse.
- ST_MAKE, unknown code: ignored, stay.
- ST_BREAK, known key k: if held[k]==1, clear held[k], pulse release[k]; -> ST_MAKE.
- ST_BREAK, RELEASED again: stay ST_BREAK. Unknown code: -> ST_MAKE, no effect.
- Action: press[SPACE] sets action_req; action_ack clears it. New SPACE press while action_req=1 ignored. Set and ack in the same cycle: ack wins, action_req=0 after.
- Timeout counter: reset to 0 on every accepted word, and held while held==0; otherwise increments. On reaching TIMEOUT_CYCLES-1: held cleared, release pulsed for every bit that was set, counter to 0, FSM -> ST_MAKE.
- Accepted word and timeout in the same cycle: word processed, timeout suppressed.
- freeze=1: no words accepted; held, timeout counter and FSM continue normally.

## Timing
- Reset values: held=0, press=0, release=0, action_req=0, FSM ST_MAKE, counter 0; key_ready = !freeze (combinational).
- Latency: word accepted at edge N -> held/press/release updated at edge N+1 (all outputs registered).
- press/release exactly one cycle wide; back-to-back accepted words produce back-to-back pulses.
- action_req rises with press[SPACE], same edge.
- Reset mid-sequence (ST_BREAK pending): break prefix discarded, all outputs to reset values asynchronously.

## Structure
- keyboardPkg gains: key index enum (KEY_W=0, KEY_A=1, KEY_S=2, KEY_D=3, KEY_SPACE=4, KEY_ENTER=5), N_KEYS=6, FSM state typedef.
- Sub-module keyboard_key_decode: combinational key_word -> {known, index}, using package codes; reusable by other consumers.
- Counter width $clog2(TIMEOUT_CYCLES).

## Test plan
- Make W (0x3144), then RELEASED (0x4630), 0x3144 -> held[0] rises, press[0] one cycle; release[0] one cycle after break, held=0.
- W make, 0x3144 repeated 5x, D make (0x3233) -> single press[0], press[3] once, held=6'b001001.
- SPACE make (0x3239) twice with break between, no ack -> action_req=1 after first, second press[4] pulses but no re-trigger; action_ack -> action_req=0.
- TIMEOUT_CYCLES=16, A make, no words -> held[1] cleared and release[1] pulse at cycle 16 after accept; word at exactly cycle 15 suppresses timeout.
- RELEASED, unknown 0x1234, then 0x3142 -> S pressed (not treated as break); freeze=1 with key_valid=1 -> key_ready=0, no state change.
- rst_n low while in ST_BREAK after S held -> all outputs 0; following 0x3142 is a make.
